// File: rtl/qm_pkg.sv
// Shared constants, state encoding and the 128-entry cosine table for the
// quadrature up-converter.
package qm_pkg;

  localparam int unsigned IWIDTH_DEF = 16;
  localparam int unsigned OWIDTH_DEF = 8;
  localparam int unsigned NLANE      = 4;
  localparam int unsigned PHW        = 7;
  localparam int unsigned LUTW       = 8;
  localparam int unsigned QUARTER    = 32;
  localparam int unsigned RND_BIAS   = 16384;
  localparam int unsigned RND_SHIFT  = 15;

  typedef enum logic {IDLE, RUN} state_t;

  // round(127*cos(2*pi*k/128)); sine is read a quarter turn behind
  localparam int COS_LUT [128] = '{
     127,  127,  126,  126,  125,  123,  122,  120,
     117,  115,  112,  109,  106,  102,   98,   94,
      90,   85,   81,   76,   71,   65,   60,   54,
      49,   43,   37,   31,   25,   19,   12,    6,
       0,   -6,  -12,  -19,  -25,  -31,  -37,  -43,
     -49,  -54,  -60,  -65,  -71,  -76,  -81,  -85,
     -90,  -94,  -98, -102, -106, -109, -112, -115,
    -117, -120, -122, -123, -125, -126, -126, -127,
    -127, -127, -126, -126, -125, -123, -122, -120,
    -117, -115, -112, -109, -106, -102,  -98,  -94,
     -90,  -85,  -81,  -76,  -71,  -65,  -60,  -54,
     -49,  -43,  -37,  -31,  -25,  -19,  -12,   -6,
       0,    6,   12,   19,   25,   31,   37,   43,
      49,   54,   60,   65,   71,   76,   81,   85,
      90,   94,   98,  102,  106,  109,  112,  115,
     117,  120,  122,  123,  125,  126,  126,  127
  };

endpackage

// File: rtl/qm_cos_lut.sv
// Registered phase-to-(cos, sin) lookup for one output lane.
module qm_cos_lut
  import qm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PHW-1:0]         ph,
  output logic signed [LUTW-1:0] cos_q,
  output logic signed [LUTW-1:0] sin_q
);

  logic signed [LUTW-1:0] cos_d;
  logic signed [LUTW-1:0] sin_d;
  logic [PHW-1:0]         sin_ph;

  always_comb begin
    sin_ph = ph - PHW'(QUARTER);
    cos_d  = LUTW'(COS_LUT[ph]);
    sin_d  = LUTW'(COS_LUT[sin_ph]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

endmodule

// File: rtl/qm_upconv.sv
// Quadrature up-converter: holds each I/Q sample INTERP clocks, mixes it with a
// 7-bit NCO and emits four consecutive real passband samples per clock.
module qm_upconv
  import qm_pkg::*;
#(
  parameter int unsigned IWIDTH = IWIDTH_DEF,
  parameter int unsigned OWIDTH = OWIDTH_DEF,
  parameter int unsigned INTERP = 4
) (
  input  logic              CLK,
  input  logic              ARST,
  input  logic              InputValid,
  output logic              InputReady,
  input  logic [IWIDTH-1:0] SigInI,
  input  logic [IWIDTH-1:0] SigInQ,
  input  logic [PHW-1:0]    freq,
  input  logic              newFreq,
  output logic [OWIDTH-1:0] dsp_out0,
  output logic [OWIDTH-1:0] dsp_out1,
  output logic [OWIDTH-1:0] dsp_out2,
  output logic [OWIDTH-1:0] dsp_out3,
  output logic              DataValid,
  output logic              Underrun
);

  localparam int unsigned HW = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam int unsigned PW = IWIDTH + LUTW;
  localparam int unsigned SW = IWIDTH + LUTW + 1;
  localparam logic [HW-1:0]        HOLD_LAST = HW'(INTERP - 1);
  localparam logic signed [SW-1:0] RND       = SW'(RND_BIAS);
  localparam logic signed [SW-1:0] OMAX      = SW'((2 ** (OWIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] OMIN      = -SW'(2 ** (OWIDTH - 1));

  state_t                 state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   ready_q, ready_d;
  logic                   underrun_q, underrun_d;
  logic [PHW-1:0]         ph_q, ph_d, freq_q, freq_d;
  logic [PHW-1:0]         ph_now, f_now;
  logic signed [IWIDTH-1:0] i0_q, i0_d, q0_q, q0_d;
  logic signed [IWIDTH-1:0] i1_q, i1_d, q1_q, q1_d;
  logic [PHW-1:0]         lph_q [NLANE];
  logic [PHW-1:0]         lph_d [NLANE];
  logic signed [LUTW-1:0] cos_w [NLANE];
  logic signed [LUTW-1:0] sin_w [NLANE];
  logic signed [PW-1:0]   pc_q [NLANE];
  logic signed [PW-1:0]   pc_d [NLANE];
  logic signed [PW-1:0]   ps_q [NLANE];
  logic signed [PW-1:0]   ps_d [NLANE];
  logic signed [SW-1:0]   sum_w [NLANE];
  logic signed [SW-1:0]   rnd_w [NLANE];
  logic [OWIDTH-1:0]      out_q [NLANE];
  logic [OWIDTH-1:0]      out_d [NLANE];
  logic                   v1_q, v1_d, v2_q, v2_d, valid_q, valid_d;
  logic                   accept, hold_last;

  assign accept    = InputValid & ready_q;
  assign hold_last = (hold_q == HOLD_LAST);

  // Handshake FSM and hold counter
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    underrun_d = 1'b0;
    i0_d       = i0_q;
    q0_d       = q0_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          hold_d  = '0;
          i0_d    = $signed(SigInI);
          q0_d    = $signed(SigInQ);
        end
      end
      RUN: begin
        if (hold_last) begin
          if (accept) begin
            hold_d = '0;
            i0_d   = $signed(SigInI);
            q0_d   = $signed(SigInQ);
          end else begin
            state_d    = IDLE;
            underrun_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (hold_d == HOLD_LAST);
  end

  // NCO: a newFreq load takes effect for the word registered on the same edge
  always_comb begin
    f_now  = newFreq ? freq : freq_q;
    ph_now = newFreq ? '0 : ph_q;
    freq_d = f_now;
    ph_d   = ph_now;
    for (int unsigned j = 0; j < NLANE; j++) lph_d[j] = lph_q[j];
    if (state_d == RUN) begin
      for (int unsigned j = 0; j < NLANE; j++) lph_d[j] = ph_now + PHW'(j * f_now);
      ph_d = ph_now + PHW'({f_now, 2'b00});
    end else if (state_q == RUN) begin
      ph_d = '0;
    end
  end

  for (genvar j = 0; j < NLANE; j++) begin : g_lane
    qm_cos_lut u_lut (
      .clk   (CLK),
      .rst_n (ARST),
      .ph    (lph_q[j]),
      .cos_q (cos_w[j]),
      .sin_q (sin_w[j])
    );
  end

  // Multiply, then I*cos - Q*sin with round-half-up and saturation
  always_comb begin
    i1_d    = i0_q;
    q1_d    = q0_q;
    v1_d    = (state_q == RUN);
    v2_d    = v1_q;
    valid_d = v2_q;
    for (int unsigned j = 0; j < NLANE; j++) begin
      pc_d[j]  = PW'(i1_q) * PW'(cos_w[j]);
      ps_d[j]  = PW'(q1_q) * PW'(sin_w[j]);
      sum_w[j] = SW'(pc_q[j]) - SW'(ps_q[j]) + RND;
      rnd_w[j] = sum_w[j] >>> RND_SHIFT;
      if (!v2_q)                out_d[j] = '0;
      else if (rnd_w[j] > OMAX) out_d[j] = OWIDTH'(OMAX);
      else if (rnd_w[j] < OMIN) out_d[j] = OWIDTH'(OMIN);
      else                      out_d[j] = OWIDTH'(rnd_w[j]);
    end
  end

  always_ff @(posedge CLK or negedge ARST) begin
    if (!ARST) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      ready_q    <= 1'b1;
      underrun_q <= 1'b0;
      ph_q       <= '0;
      freq_q     <= '0;
      i0_q       <= '0;
      q0_q       <= '0;
      i1_q       <= '0;
      q1_q       <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      valid_q    <= 1'b0;
      for (int unsigned j = 0; j < NLANE; j++) begin
        lph_q[j] <= '0;
        pc_q[j]  <= '0;
        ps_q[j]  <= '0;
        out_q[j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      ph_q       <= ph_d;
      freq_q     <= freq_d;
      i0_q       <= i0_d;
      q0_q       <= q0_d;
      i1_q       <= i1_d;
      q1_q       <= q1_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      valid_q    <= valid_d;
      for (int unsigned j = 0; j < NLANE; j++) begin
        lph_q[j] <= lph_d[j];
        pc_q[j]  <= pc_d[j];
        ps_q[j]  <= ps_d[j];
        out_q[j] <= out_d[j];
      end
    end
  end

  assign InputReady = ready_q;
  assign Underrun   = underrun_q;
  assign DataValid  = valid_q;
  assign dsp_out0   = out_q[0];
  assign dsp_out1   = out_q[1];
  assign dsp_out2   = out_q[2];
  assign dsp_out3   = out_q[3];

endmodule

// File: doc/qm_upconv.md
# qm_upconv

Quadrature up-converter and interpolator: the transmit-side counterpart of the QM/FIR decimation receive chain. Accepts complex baseband samples (I/Q) at a low rate via a valid/ready handshake, holds each sample for INTERP clocks, mixes it with a 7-bit-frequency NCO, and emits four consecutive real passband samples per clock on the same 4-lane parallel format the receive front end consumes.

## Interface
- IWIDTH, 16: signed width of I/Q inputs
- OWIDTH, 8: signed width of each output lane
- INTERP, 4: clocks each accepted I/Q sample is held, ≥1
- CLK  in  1  clock
- ARST  in  1  asynchronous, active-low reset
- InputValid  in  1  I/Q sample offered
- InputReady  out  1  block will take the sample this cycle
- SigInI, SigInQ  in  IWIDTH  signed baseband I and Q
- freq  in  7  NCO step, in 1/128 cycle per output sample
- newFreq  in  1  load freq and zero the NCO phase
- dsp_out0..dsp_out3  out  OWIDTH each  four consecutive output samples, lane 0 earliest
- DataValid  out  1  lanes carry valid samples
- Underrun  out  1  one-cycle pulse when the hold expires with no sample waiting

## Operation
- Accept = InputValid & InputReady. InputReady = (state==IDLE) | (holdcnt==INTERP-1). It depends only on registers, not on InputValid.
- States:
  - IDLE: on accept, go to RUN and set holdcnt=0.
  - RUN: holdcnt increments each cycle. At INTERP-1, an accept reloads I/Q and sets holdcnt=0. With no accept, raise Underrun for one cycle, go to IDLE, and reset the phase to 0.
- NCO: 7-bit phase ph. Lane j uses (ph + j·freq_r) mod 128. In RUN, ph += 4·freq_r mod 128 each cycle. In IDLE, ph holds.
- newFreq: freq_r<=freq and ph<=0 on the same edge. If this coincides with an accept, the accepted sample's first cycle uses phase 0 and the new freq.
- LUT: cos[k] = round(127·cos(2πk/128)), signed 8-bit. sin[k] = cos[(k-32) mod 128].
- Per lane: s = I·cos − Q·sin, computed full precision in IWIDTH+9 bits. Then r = (s + 2^14) >>> 15 (arithmetic). Saturate r to [−2^(OWIDTH−1), 2^(OWIDTH−1)−1].
- Reset values: all outputs 0, InputReady 1, DataValid 0, Underrun 0, ph 0, freq_r 0, state IDLE.
- Reset mid-operation flushes the pipeline. DataValid drops immediately (asynchronously).

## Timing
- Pipeline has 4 register stages:
  - Edge t (accept): I/Q hold registers and lane phases.
  - t+1: LUT outputs.
  - t+2: products.
  - t+3: sum, round, saturate into dsp_out*, with DataValid=1.
- Latency is 3 clocks from the accept edge to the first valid output edge. With no underrun, DataValid stays high continuously, one 4-sample word per clock, INTERP words per input sample.
- DataValid follows the RUN state delayed by 3 clocks. Underrun is visible in the cycle after the last hold cycle. The final held words still drain; data is zero in IDLE.
- With INTERP=1, InputReady is high every RUN cycle, so back-to-back accepts are allowed.
- A sample offered during IDLE is taken in the same cycle.

## Structure
- Package qm_pkg holds:
  - OWIDTH/IWIDTH defaults and the rounding constant 2^14.
  - The 128-entry cos LUT as a constant array.
  - The state enum {IDLE, RUN}.
- Sub-module qm_cos_lut: registered 7-bit phase → signed 8-bit cos/sin pair, instantiated once per lane (4×).
- Top level holds the handshake FSM, hold counter, NCO, multipliers and round/saturate.

## Test plan
- Reset, freq=0, I=16384, Q=0, held → from 3 clocks after accept, all lanes = 64 and DataValid=1; before that all zeros.
- freq=32 (newFreq), I=16384, Q=0 → lanes = 64, 0, −63, 0 every cycle (phase wraps by 128).
- freq=16, I=32767, Q=−32768 → lanes = 127, 127 (saturated from 180), 127, 0.
- INTERP=4, InputValid held high, 3 samples → InputReady high once every 4 cycles, exactly 3 accepts, 12 valid words, then Underrun pulse and InputReady stays high.
- Withhold the sample at holdcnt=3 → Underrun for 1 cycle, DataValid low 3 cycles later; next accept restarts with phase 0.
- Assert ARST mid-RUN → outputs 0, DataValid 0, InputReady 1 immediately; the first post-reset accept behaves as in scenario 1.
